// File: rtl/comb_result_pkg.sv
// Shared types and widths for the combinational-result buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package comb_result_pkg;

    localparam int R1_W      = 5;
    localparam int R2_W      = 8;
    localparam int R3_W      = 4;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;

    // One buffered result, overflow flag in the MSB.
    typedef struct packed {
        logic            overflow;
        logic [R3_W-1:0] result3;
        logic [R2_W-1:0] result2;
        logic [R1_W-1:0] result1;
    } entry_t;

    // Occupancy state of the buffer.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } occ_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones.
// Latency: count reflects an increment one clock after inc_i.
// Backpressure: none; increments beyond saturation are ignored.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    // Count up on each event until every bit is set, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/comb_result_fifo.sv
// Show-ahead result buffer behind a combinational stage, with drop/overflow stats.
// Latency: an entry pushed at edge N is visible on out_* from edge N; no bypass when empty.
// Backpressure: in_ready low when full; pushes attempted while full are dropped and counted.
module comb_result_fifo
    import comb_result_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     in_valid,
    input  logic [R1_W-1:0]          in_result1,
    input  logic [R2_W-1:0]          in_result2,
    input  logic [R3_W-1:0]          in_result3,
    input  logic                     in_overflow,
    input  logic                     flush,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [R1_W-1:0]          out_result1,
    output logic [R2_W-1:0]          out_result2,
    output logic [R3_W-1:0]          out_result3,
    output logic                     out_overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         ovf_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    occ_e           state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    entry_t         mem_q [DEPTH];
    entry_t         wr_entry;
    entry_t         head;

    logic push, pop, drop, ovf_inc;

    // Flush wins over everything: nothing is stored, popped or counted that cycle.
    assign push    = in_valid & clk_en & (state_q != ST_FULL) & ~flush;
    assign pop     = (state_q != ST_EMPTY) & out_ready & ~flush;
    assign drop    = in_valid & clk_en & (state_q == ST_FULL) & ~flush;
    assign ovf_inc = push & in_overflow;

    assign wr_entry = '{overflow: in_overflow, result3: in_result3,
                        result2: in_result2, result1: in_result1};

    // Next-state for pointers, occupancy count and occupancy state.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            state_d  = ST_EMPTY;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            case (state_q)
                ST_EMPTY:   if (push) state_d = ST_PARTIAL;
                ST_PARTIAL: begin
                    if (push && !pop && (count_q == CW'(DEPTH - 1)))
                        state_d = ST_FULL;
                    else if (pop && !push && (count_q == CW'(1)))
                        state_d = ST_EMPTY;
                end
                ST_FULL:    if (pop) state_d = ST_PARTIAL;
                default:    state_d = ST_EMPTY;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; unreset because the output gate hides it while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head = (state_q == ST_EMPTY) ? entry_t'('0) : mem_q[rd_ptr_q];

    assign out_result1  = head.result1;
    assign out_result2  = head.result2;
    assign out_result3  = head.result3;
    assign out_overflow = head.overflow;
    assign full         = (state_q == ST_FULL);
    assign empty        = (state_q == ST_EMPTY);
    assign in_ready     = ~full;
    assign out_valid    = ~empty;
    assign count        = count_q;

    sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (drop),
        .cnt_o (drop_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (ovf_inc),
        .cnt_o (ovf_cnt)
    );

endmodule

// File: tb/tb_comb_result_fifo.sv
// Bench for comb_result_fifo: directed scenarios plus random traffic vs a queue model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised via random out_ready and deliberate overfill.
module tb_comb_result_fifo;
    import comb_result_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clk_en = 1'b0;
    logic            in_valid = 1'b0;
    logic [R1_W-1:0] in_result1 = '0;
    logic [R2_W-1:0] in_result2 = '0;
    logic [R3_W-1:0] in_result3 = '0;
    logic            in_overflow = 1'b0;
    logic            flush = 1'b0;
    logic            out_ready = 1'b0;
    logic            in_ready, out_valid, out_overflow, full, empty;
    logic [R1_W-1:0] out_result1;
    logic [R2_W-1:0] out_result2;
    logic [R3_W-1:0] out_result3;
    logic [CW-1:0]   count;
    logic [CNT_W-1:0] drop_cnt, ovf_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain queue of stored entries plus two event tallies.
    entry_t mq[$];
    int     m_drop = 0;
    int     m_ovf  = 0;

    comb_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_en       (clk_en),
        .in_valid     (in_valid),
        .in_result1   (in_result1),
        .in_result2   (in_result2),
        .in_result3   (in_result3),
        .in_overflow  (in_overflow),
        .flush        (flush),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result1  (out_result1),
        .out_result2  (out_result2),
        .out_result3  (out_result3),
        .out_overflow (out_overflow),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .drop_cnt     (drop_cnt),
        .ovf_cnt      (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ce, input logic [R1_W-1:0] r1,
                         input logic [R2_W-1:0] r2, input logic [R3_W-1:0] r3,
                         input logic ovf, input logic ordy, input logic fl);
        in_valid    = v;
        clk_en      = ce;
        in_result1  = r1;
        in_result2  = r2;
        in_result3  = r3;
        in_overflow = ovf;
        out_ready   = ordy;
        flush       = fl;
    endtask

    // Apply the rules for one rising edge using the currently driven inputs.
    task automatic model_edge();
        entry_t e;
        bit     is_full;
        if (flush) begin
            mq.delete();
        end else begin
            is_full = (mq.size() == DEPTH);
            if (in_valid && clk_en && is_full && m_drop < MAXC) m_drop++;
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && clk_en && !is_full) begin
                e.overflow = in_overflow;
                e.result3  = in_result3;
                e.result2  = in_result2;
                e.result1  = in_result1;
                mq.push_back(e);
                if (in_overflow && m_ovf < MAXC) m_ovf++;
            end
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_drop = 0;
        m_ovf  = 0;
    endtask

    task automatic check_all(input string tag);
        entry_t h;
        int     n;
        n = mq.size();
        h = (n > 0) ? mq[0] : entry_t'('0);
        chk({tag, ".vld"},   32'(out_valid),    32'(n > 0));
        chk({tag, ".r1"},    32'(out_result1),  32'(h.result1));
        chk({tag, ".r2"},    32'(out_result2),  32'(h.result2));
        chk({tag, ".r3"},    32'(out_result3),  32'(h.result3));
        chk({tag, ".ovf"},   32'(out_overflow), 32'(h.overflow));
        chk({tag, ".cnt"},   32'(count),        32'(n));
        chk({tag, ".full"},  32'(full),         32'(n == DEPTH));
        chk({tag, ".empty"}, 32'(empty),        32'(n == 0));
        chk({tag, ".rdy"},   32'(in_ready),     32'(n != DEPTH));
        chk({tag, ".dropc"}, 32'(drop_cnt),     32'(m_drop));
        chk({tag, ".ovfc"},  32'(ovf_cnt),      32'(m_ovf));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int saved_drop;
        int saved_ovf;

        // Reset values while held in reset.
        #3;
        check_all("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single push, visible after the capturing edge.
        drive(1, 1, 5'h13, 8'hA5, 4'h6, 1, 0, 0);
        step("push1");
        chk("push1.r1c", 32'(out_result1), 32'h13);
        chk("push1.r2c", 32'(out_result2), 32'hA5);
        chk("push1.r3c", 32'(out_result3), 32'h6);
        chk("push1.ovc", 32'(ovf_cnt),     32'd1);
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        step("pop1");

        // Overfill: five pushes into four slots, then drain in order.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 5'(i + 1), 8'(8'h10 + i), 4'(i), 0, 0, 0);
            step("fill");
        end
        chk("fill.fullc", 32'(full),     32'd1);
        chk("fill.rdyc",  32'(in_ready), 32'd0);
        chk("fill.dropc", 32'(drop_cnt), 32'd1);
        for (int j = 0; j < 4; j++) begin
            chk("drain.order", 32'(out_result1), 32'(j + 1));
            drive(0, 1, 0, 0, 0, 0, 1, 0);
            step("drain");
        end

        // Steady push+pop at occupancy 2 across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 5'(i + 20), 8'(i), 4'(i), 0, 0, 0);
            step("pre2");
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 5'(i), 8'(8'h80 + i), 4'(15 - i), 1'(i), 1, 0);
            step("pp");
            chk("pp.cnt2", 32'(count), 32'd2);
        end

        // Capture disabled: no push, no drop.
        saved_drop = m_drop;
        drive(1, 0, 5'h1F, 8'hFF, 4'hF, 1, 0, 0);
        step("noce");
        chk("noce.cnt",  32'(count),    32'd2);
        chk("noce.drop", 32'(drop_cnt), 32'(saved_drop));

        // Flush with concurrent push and pop at count 3.
        drive(1, 1, 5'h07, 8'h07, 4'h7, 1, 0, 0);
        step("to3");
        chk("to3.cnt", 32'(count), 32'd3);
        saved_drop = m_drop;
        saved_ovf  = m_ovf;
        drive(1, 1, 5'h08, 8'h08, 4'h8, 1, 1, 1);
        step("flush");
        chk("flush.cnt",   32'(count),    32'd0);
        chk("flush.empty", 32'(empty),    32'd1);
        chk("flush.drop",  32'(drop_cnt), 32'(saved_drop));
        chk("flush.ovf",   32'(ovf_cnt),  32'(saved_ovf));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  5'($urandom), 8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
            step("rnd");
        end

        // Drive drop counter to saturation.
        drive(0, 1, 0, 0, 0, 0, 0, 1);
        step("sflush");
        for (int i = 0; i < 300 + DEPTH; i++) begin
            drive(1, 1, 5'($urandom), 8'($urandom), 4'($urandom), 0, 0, 0);
            step("sat");
        end
        chk("sat.drop", 32'(drop_cnt), 32'd255);

        // Asynchronous reset pulse between edges.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        chk("arst.cnt",  32'(count),    32'd0);
        chk("arst.drop", 32'(drop_cnt), 32'd0);
        #2;
        rst_n = 1'b1;
        drive(1, 1, 5'h0A, 8'h5C, 4'h3, 0, 0, 0);
        step("post");
        chk("post.first", 32'(out_result1), 32'h0A);
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        step("post.pop");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/comb_result_fifo.md
COMB_RESULT_FIFO -- requirements
Module: comb_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered result entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter CNT_W, default 8, width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clk_en  input  1  capture enable; push is qualified by it.
REQ-006 in_valid  input  1  upstream combinational stage presents a valid result.
REQ-007 in_result1 / in_result2 / in_result3  input  5 / 8 / 4  result word from the combinational stage.
REQ-008 in_overflow  input  1  overflow flag accompanying the result.
REQ-009 flush  input  1  synchronous discard of all buffered entries.
REQ-010 in_ready  output  1  asserted when an entry can be accepted (not full).
REQ-011 out_valid  output  1  head entry available (not empty).
REQ-012 out_ready  input  1  downstream consumer accepts the head entry.
REQ-013 out_result1 / out_result2 / out_result3 / out_overflow  output  5 / 8 / 4 / 1  head entry fields.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 full, empty  output  1 each  occupancy flags.
REQ-016 drop_cnt, ovf_cnt  output  CNT_W each  dropped-push count; accepted-overflow count.

Function
REQ-017 push SHALL occur when in_valid & clk_en & in_ready; pop SHALL occur when out_valid & out_ready, independent of clk_en.
REQ-018 Show-ahead: an entry pushed at edge N SHALL drive out_* and out_valid=1 from edge N onward; no same-cycle bypass when empty.
REQ-019 out_* SHALL be driven from storage only; when empty, out_* SHALL be 0.
REQ-020 Simultaneous push and pop when neither empty nor full SHALL leave count unchanged and preserve order.
REQ-021 When full, in_ready=0; in_valid & clk_en while full SHALL increment drop_cnt and not alter storage, even if a pop occurs in the same cycle.
REQ-022 Write and read pointers SHALL wrap modulo DEPTH; full when count==DEPTH, empty when count==0.
REQ-023 Occupancy states EMPTY, PARTIAL, FULL: EMPTY->PARTIAL on push; PARTIAL->FULL on push without pop at count==DEPTH-1; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop without push at count==1; flush->EMPTY from any state.
REQ-024 flush SHALL take priority over push and pop in the same cycle: pointers and count cleared, the concurrent push discarded and not counted as a drop.
REQ-025 ovf_cnt SHALL increment on each accepted push with in_overflow=1.
REQ-026 Both counters SHALL saturate at 2^CNT_W-1 and are cleared only by reset, not by flush.
REQ-027 Entry fields SHALL be stored unmodified; no width extension or truncation.

Reset
REQ-028 rst_n low SHALL asynchronously force count=0, empty=1, full=0, out_valid=0, in_ready=1, out_*=0, drop_cnt=0, ovf_cnt=0, pointers=0.
REQ-029 Storage array contents need not be reset; they SHALL never be observable while empty.
REQ-030 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion is the first entry returned.

Structure
REQ-031 Package comb_result_pkg SHALL hold R1_W=5, R2_W=8, R3_W=4, default DEPTH and CNT_W, and the packed entry typedef {overflow, result3, result2, result1}.
REQ-032 One sub-module, sat_counter (parameter width, inc input, saturating, async active-low reset), SHALL be instantiated for drop_cnt and ovf_cnt.

Verification
REQ-033 Reset, then push {r1=5'h13,r2=8'hA5,r3=4'h6,ovf=1} with clk_en=1 -> out_valid=1 next cycle with the same values, count=1, ovf_cnt=1.
REQ-034 Push 5 entries with out_ready=0, DEPTH=4 -> full=1 after the 4th, in_ready=0, drop_cnt=1, entries 1-4 pop in order.
REQ-035 With count=2, push and pop in the same cycle for 10 cycles -> count stays 2, output sequence matches input order across pointer wrap.
REQ-036 in_valid=1, clk_en=0 -> no push, count unchanged, drop_cnt unchanged.
REQ-037 count=3 with flush, push and pop in the same cycle -> count=0, empty=1, drop_cnt and ovf_cnt unchanged.
REQ-038 Force 300 dropped pushes -> drop_cnt=255 held; rst_n pulse mid-stream -> all outputs at reset values immediately, without waiting for a clock edge.
